// File: rtl/oam_dma_pkg.sv
// Shared types and register addresses for the sprite DMA engine.
// Build option: OAM_DMA_ALIGN_EN adds the odd-cycle ALIGN state.
package oam_dma_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  localparam logic [ADDR_W-1:0] REG_OAMDMA  = 16'h4014;
  localparam logic [ADDR_W-1:0] REG_OAMDATA = 16'h2004;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

  function automatic logic is_hit(
    input logic              we,
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] match
  );
    return we && (addr == match);
  endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: halts the CPU and copies one 256-byte page to OAMDATA.
// Build option: OAM_DMA_ALIGN_EN enables parity-based ALIGN cycle.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int                ADDR_N  = ADDR_W,
  parameter int                DATA_N  = DATA_W,
  parameter logic [ADDR_N-1:0] REG_DMA = REG_OAMDMA,
  parameter logic [ADDR_N-1:0] REG_OAM = REG_OAMDATA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_N-1:0] cpu_addr,
  input  logic [DATA_N-1:0] cpu_data,
  input  logic              cpu_we,
  output logic              cpu_rdy,
  output logic              bus_req,
  output logic [ADDR_N-1:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_N-1:0] bus_dout,
  input  logic [DATA_N-1:0] bus_din,
  output logic              busy
);

  dma_state_t        state_q, state_d;
  logic [DATA_N-1:0] page_q, page_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_N-1:0] data_q, data_d;
  logic              trig;
  logic              go_align;
  logic [ADDR_N-1:0] src_addr;

  assign trig     = is_hit(cpu_we, cpu_addr, REG_DMA);
  assign src_addr = ADDR_N'({page_q, cnt_q});

`ifdef OAM_DMA_ALIGN_EN
  logic parity_q, parity_d;

  assign parity_d = ~parity_q;
  assign go_align = parity_q;

  always_ff @(posedge clk) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
`else
  assign go_align = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DMA_IDLE;
      page_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      DMA_IDLE: begin
        if (trig) begin
          page_d  = cpu_data;
          cnt_d   = '0;
          state_d = DMA_HALT;
        end
      end
      // CPU cannot stop on a write cycle; wait for its first read
      DMA_HALT: begin
        if (!cpu_we)
          state_d = go_align ? DMA_ALIGN : DMA_READ;
      end
      DMA_ALIGN: state_d = DMA_READ;
      DMA_READ: begin
        data_d  = bus_din;
        state_d = DMA_WRITE;
      end
      DMA_WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == '1) ? DMA_IDLE : DMA_READ;
      end
      default: state_d = DMA_IDLE;
    endcase
  end

  always_comb begin
    cpu_rdy  = (state_q == DMA_IDLE);
    busy     = !cpu_rdy;
    bus_req  = 1'b0;
    bus_we   = 1'b0;
    bus_addr = '0;
    bus_dout = '0;
    unique case (state_q)
      DMA_ALIGN, DMA_READ: begin
        bus_req  = 1'b1;
        bus_addr = src_addr;
      end
      DMA_WRITE: begin
        bus_req  = 1'b1;
        bus_we   = 1'b1;
        bus_addr = REG_OAM;
        bus_dout = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a read/write scoreboard.
// Honours OAM_DMA_ALIGN_EN when computing expected stall length.
module tb_oam_dma;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_we;
  logic        cpu_rdy;
  logic        bus_req;
  logic [15:0] bus_addr;
  logic        bus_we;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  exp_t        q[$];
  int          stall_cnt;
  int          halt_cnt;
  int          wr_seen;
  logic        exit_par;
  logic        tb_par;
  logic [15:0] last_rd;
  logic        rd_vld;
  logic        saw_zero;

  oam_dma dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_we   (cpu_we),
    .cpu_rdy  (cpu_rdy),
    .bus_req  (bus_req),
    .bus_addr (bus_addr),
    .bus_we   (bus_we),
    .bus_dout (bus_dout),
    .bus_din  (bus_din),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return {a[3:0], a[7:4]} ^ a[15:8] ^ 8'h3C;
  endfunction

  assign bus_din = mem(bus_addr);

  always @(posedge clk) tb_par <= reset ? 1'b0 : ~tb_par;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!cpu_rdy) stall_cnt++;
    if (!cpu_rdy && !bus_req) begin
      halt_cnt++;
      if (!cpu_we) exit_par = tb_par;
    end
    if (bus_req && bus_addr == 16'h0000) saw_zero = 1'b1;
    if (bus_req && !bus_we) begin
      last_rd = bus_addr;
      rd_vld  = 1'b1;
    end
    if (bus_req && bus_we) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("rd_addr", {15'd0, rd_vld, last_rd}, {15'd0, 1'b1, e.a});
        chk("wr_addr", 32'(bus_addr), 32'h2004);
        chk("wr_data", 32'(bus_dout), 32'(e.d));
      end
      wr_seen++;
      rd_vld = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_page(input logic [7:0] page);
    for (int i = 0; i < 256; i++) begin
      exp_t e;
      e.a = {page, 8'(i)};
      e.d = mem(e.a);
      q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (cpu_rdy) break;
      tick();
    end
    chk(tag, 32'(cpu_rdy), 32'd1);
  endtask

  task automatic run_xfer(input logic [7:0] page, input int hold);
    int extra;
    push_page(page);
    stall_cnt = 0;
    halt_cnt  = 0;
    wr_seen   = 0;
    rd_vld    = 1'b0;
    cpu_addr  = 16'h4014;
    cpu_data  = page;
    cpu_we    = 1'b1;
    tick();
    chk("rdy_low_next", {30'd0, cpu_rdy, busy}, 32'b01);
    repeat (hold) tick();
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_data = 8'h00;
    wait_idle("xfer_timeout");
`ifdef OAM_DMA_ALIGN_EN
    extra = int'(exit_par);
`else
    extra = 0;
`endif
    chk("stall_len", 32'(stall_cnt), 32'(hold + 1 + 512 + extra));
    chk("halt_len", 32'(halt_cnt), 32'(hold + 1));
    chk("wr_count", 32'(wr_seen), 32'd256);
    chk("sb_empty", 32'(q.size()), 32'd0);
    chk("idle_out", {29'd0, busy, bus_req, bus_we}, 32'd0);
  endtask

  initial begin
    bit found;
    reset    = 1'b1;
    cpu_addr = 16'h0000;
    cpu_data = 8'h00;
    cpu_we   = 1'b0;
    saw_zero = 1'b0;
    rd_vld   = 1'b0;
    wr_seen  = 0;
    repeat (2) tick();
    chk("rst_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_dout", 32'(bus_dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // reset and trigger together: reset wins
    cpu_addr = 16'h4014;
    cpu_data = 8'h02;
    cpu_we   = 1'b1;
    tick();
    chk("rst_trig_rdy", 32'(cpu_rdy), 32'd1);
    reset  = 1'b0;
    cpu_we = 1'b0;
    tick();

    // writes elsewhere and reads of 4014 are ignored
    cpu_addr = 16'h4015;
    cpu_data = 8'h02;
    cpu_we   = 1'b1;
    tick();
    chk("w4015_rdy", {30'd0, cpu_rdy, busy}, 32'b10);
    cpu_addr = 16'h4014;
    cpu_we   = 1'b0;
    repeat (2) tick();
    chk("r4014_rdy", {30'd0, cpu_rdy, busy}, 32'b10);
    chk("r4014_req", 32'(bus_req), 32'd0);

    run_xfer(8'h02, 0);
    tick();
    run_xfer(8'h05, 0);
    run_xfer(8'h07, 2);

    // reset in the WRITE cycle with cnt=100
    push_page(8'h01);
    wr_seen  = 0;
    rd_vld   = 1'b0;
    cpu_addr = 16'h4014;
    cpu_data = 8'h01;
    cpu_we   = 1'b1;
    tick();
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    found    = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (bus_we && wr_seen == 100) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("find_cnt100", 32'(found), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    chk("midrst_rdy", 32'(cpu_rdy), 32'd1);
    chk("midrst_req", 32'(bus_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    tick();
    run_xfer(8'h03, 0);

    saw_zero = 1'b0;
    run_xfer(8'hFF, 0);
    chk("no_0000", 32'(saw_zero), 32'd0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
